// File: rtl/instr_fetch.sv
`timescale 1ns/1ps
// instr_fetch: fetch stage ahead of instr_decode.
// Owns the PC and issues one-outstanding word fetches on a req/ready port.
// Returned words go into a small FIFO whose head is presented, registered, to decode.
// Redirects from execute flush the FIFO and any in-flight word.
// Ports:
//   clk, reset (async, active-low)
//   imem_req/imem_addr   -> instruction memory request (held until imem_ready)
//   imem_ready/imem_rdata <- completion and returned word
//   redirect/redirect_pc  <- taken branch/jump target from execute
//   stall                 <- decode back-pressure
//   instr/pc_out/instr_valid -> FIFO head to decode (NOP/0 when empty)
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP        = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               req_q, req_d;
  logic [31:0]        addr_q, addr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        pc_out_q, pc_out_d;
  logic               valid_q, valid_d;

  logic [31:0]        fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]        fifo_instr_q [FIFO_DEPTH];

  logic               done_c;
  logic               pop_c;
  logic               push_c;
  logic [CNT_W-1:0]   count_kept_c;
  logic [CNT_W-1:0]   count_next_c;
  logic               credit_c;
  logic [31:0]        target_c;
  logic               rpc_low_unused;

  // Word-aligned redirect target; the two low bits carry no meaning.
  assign target_c       = {redirect_pc[31:2], 2'b00};
  assign rpc_low_unused = ^redirect_pc[1:0];

  // Handshake events for this cycle; a redirect overrides both pop and push.
  assign done_c = req_q & imem_ready;
  assign pop_c  = valid_q & ~stall & ~redirect;
  assign push_c = done_c & (state_q == FETCH) & ~redirect;

  // Occupancy after this edge; a same-cycle pop frees its slot for a new request.
  assign count_kept_c = count_q - CNT_W'(pop_c);
  assign count_next_c = redirect ? '0 : (count_kept_c + CNT_W'(push_c));
  assign credit_c     = (count_next_c < DEPTH_C);

  // Next-state, request and FIFO-head computation.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    addr_d   = addr_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    valid_d  = 1'b0;
    instr_d  = NOP;
    pc_out_d = '0;

    case (state_q)
      IDLE: begin
        if (redirect) pc_d = target_c;
        if (credit_c) begin
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = pc_d;
        end
      end

      FETCH: begin
        if (redirect) begin
          pc_d = target_c;
          if (done_c) begin
            // Returned word belongs to the old path; restart at the target.
            addr_d = target_c;
          end else begin
            // Request cannot be withdrawn; wait it out and drop the data.
            state_d = DISCARD;
          end
        end else if (done_c) begin
          pc_d = pc_q + PC_STEP;
          if (credit_c) begin
            addr_d = pc_q + PC_STEP;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
            addr_d  = pc_q + PC_STEP;
          end
        end
      end

      DISCARD: begin
        if (redirect) pc_d = target_c;
        if (done_c) begin
          addr_d = pc_d;
          if (credit_c) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    // FIFO pointers
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    // Registered head: bypass the incoming word when it lands in an empty FIFO.
    if (count_next_c != '0) begin
      valid_d = 1'b1;
      if (push_c && (count_kept_c == '0)) begin
        instr_d  = imem_rdata;
        pc_out_d = addr_q;
      end else begin
        instr_d  = fifo_instr_q[rd_ptr_d];
        pc_out_d = fifo_pc_q[rd_ptr_d];
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      instr_q  <= NOP;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_next_c;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_pc_q[wr_ptr_q]    <= addr_q;
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
// Self-checking bench for instr_fetch: cycle table for startup/stall, directed
// redirect/reset sequences, a wrap-around instance and a randomized phase,
// with an in-order PC scoreboard on every word decode accepts.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        instr_valid;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_instr;
  logic [31:0] w_pc_out;
  logic        w_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int lat      = 1;
  int held     = 0;
  logic        pend      = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic        mon_en    = 1'b0;
  logic [31:0] exp_q [$];

  instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2), .NOP(NOP)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .instr(instr), .pc_out(pc_out), .instr_valid(instr_valid)
  );

  // Zero-wait memory for the wrap-around instance: ready follows req directly.
  assign w_rdata = w_addr | 32'h13;

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2), .NOP(NOP)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(w_req), .imem_rdata(w_rdata),
    .redirect(1'b0), .redirect_pc(32'h0), .stall(1'b0),
    .instr(w_instr), .pc_out(w_pc_out), .instr_valid(w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_restart(input logic [31:0] start);
    exp_q.delete();
    for (int k = 0; k < 1024; k++) exp_q.push_back(start + 32'(k * 4));
  endtask

  // Memory model: ready after 'lat' cycles of a held request; also checks
  // that a pending request stays asserted with a stable address.
  initial begin
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 1'b0; held = 0; imem_ready = 1'b0;
      end else begin
        if (pend) begin
          chk("req_held", 32'(imem_req), 32'h1);
          chk("addr_stable", imem_addr, pend_addr);
        end
        if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'h0);
        if (!imem_req) begin
          held = 0; imem_ready = 1'b0;
        end else if (held >= lat - 1) begin
          held = 0; imem_ready = 1'b1;
        end else begin
          held++; imem_ready = 1'b0;
        end
        pend      = imem_req && !imem_ready;
        pend_addr = imem_addr;
      end
      imem_rdata = imem_ready ? (imem_addr | 32'h13) : 32'hBAD0_BAD0;
    end
  end

  // Scoreboard: each word decode accepts must be the next expected PC.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && reset) begin
        if (instr_valid) begin
          if (!stall && !redirect) begin
            if (exp_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL sb_empty: got pc %h, expected no output", pc_out);
            end else begin
              e = exp_q.pop_front();
              n_pops++;
              chk("sb_pc", pc_out, e);
              chk("sb_instr", instr, e | 32'h13);
            end
          end
        end else begin
          chk("idle_instr", instr, NOP);
          chk("idle_pc", pc_out, 32'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        wvalid;
    logic [31:0] wpc;
  } vec_t;

  vec_t tbl [12];
  logic [31:0] frozen;
  logic        found;

  initial begin
    // cycle table from reset release: zero-wait memory, stall over cycles 3..7
    tbl[0]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 1'b0, 32'h0000_0000};
    tbl[2]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00, 1'b1, 32'hFFFF_FFF8};
    tbl[3]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04, 1'b1, 32'hFFFF_FFFC};
    tbl[4]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04, 1'b1, 32'h0000_0000};
    tbl[5]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04, 1'b1, 32'h0000_0004};
    tbl[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04, 1'b1, 32'h0000_0008};
    tbl[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04, 1'b1, 32'h0000_000C};
    tbl[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h04, 1'b1, 32'h0000_0010};
    tbl[9]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h08, 1'b1, 32'h0000_0014};
    tbl[10] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h0C, 1'b1, 32'h0000_0018};
    tbl[11] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h10, 1'b1, 32'h0000_001C};

    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_waddr", w_addr, 32'hFFFF_FFF8);

    // startup, streaming, stall with full FIFO, wrap-around instance
    @(posedge clk); #1;
    reset = 1'b1; sb_restart(32'h0); mon_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      stall = tbl[i].stall;
      @(negedge clk);
      chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_pc", i), pc_out, tbl[i].pc);
      chk($sformatf("tbl%0d_instr", i), instr, tbl[i].valid ? (tbl[i].pc | 32'h13) : NOP);
      chk($sformatf("tbl%0d_wvalid", i), 32'(w_valid), 32'(tbl[i].wvalid));
      chk($sformatf("tbl%0d_wpc", i), w_pc_out, tbl[i].wpc);
      @(posedge clk); #1;
    end

    // redirect coincident with imem_ready and a pending pop, misaligned target
    redirect = 1'b1; redirect_pc = 32'h0000_0102; sb_restart(32'h100);
    @(negedge clk);
    chk("r5_valid_before", 32'(instr_valid), 32'h1);
    chk("r5_req_before", 32'(imem_req), 32'h1);
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("r5_valid", 32'(instr_valid), 32'h0);
    chk("r5_instr", instr, NOP);
    chk("r5_req", 32'(imem_req), 32'h1);
    chk("r5_addr", imem_addr, 32'h100);
    @(negedge clk);
    chk("r5_first_valid", 32'(instr_valid), 32'h1);
    chk("r5_first_pc", pc_out, 32'h100);

    // stall with 3-cycle memory: FIFO fills, request drops, head frozen
    @(posedge clk); #1;
    lat = 3; stall = 1'b1;
    @(negedge clk);
    frozen = pc_out;
    chk("st_head", pc_out, 32'h104);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("st_valid", 32'(instr_valid), 32'h1);
      chk("st_frozen", pc_out, frozen);
      if (k >= 3) chk("st_req_low", 32'(imem_req), 32'h0);
    end
    @(posedge clk); #1;
    stall = 1'b0;
    repeat (30) @(posedge clk);

    // async reset while a request is outstanding
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (imem_req) found = 1'b1;
    end
    chk("r1_found_req", 32'(found), 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("r1_req", 32'(imem_req), 32'h0);
    chk("r1_valid", 32'(instr_valid), 32'h0);
    chk("r1_instr", instr, NOP);
    chk("r1_pc", pc_out, 32'h0);
    chk("r1_addr", imem_addr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1; sb_restart(32'h0);
    @(negedge clk);
    chk("r1_rel_req0", 32'(imem_req), 32'h0);
    @(negedge clk);
    chk("r1_rel_req1", 32'(imem_req), 32'h1);
    chk("r1_rel_addr", imem_addr, 32'h0);

    // redirect while the request to 0x8 is pending (ready two cycles later)
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk); #1;
      if (imem_req && imem_addr == 32'h4 && imem_ready) found = 1'b1;
    end
    chk("r4_found", 32'(found), 32'h1);
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h0000_07D0; sb_restart(32'h7D0);
    @(negedge clk);
    chk("r4_req_pend", 32'(imem_req), 32'h1);
    chk("r4_addr_pend", imem_addr, 32'h8);
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("r4_valid_flushed", 32'(instr_valid), 32'h0);
    chk("r4_addr_hold", imem_addr, 32'h8);
    @(negedge clk);
    chk("r4_addr_hold2", imem_addr, 32'h8);
    @(negedge clk);
    chk("r4_req_new", 32'(imem_req), 32'h1);
    chk("r4_addr_new", imem_addr, 32'h7D0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (instr_valid) found = 1'b1;
    end
    chk("r4_got_valid", 32'(found), 32'h1);
    chk("r4_first_pc", pc_out, 32'h7D0);

    // randomized stall/redirect/latency mix against the scoreboard
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      lat   = $urandom_range(1, 3);
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect    = 1'b1;
        redirect_pc = $urandom;
        sb_restart({redirect_pc[31:2], 2'b00});
      end else begin
        redirect = 1'b0;
      end
    end
    @(posedge clk); #1;
    redirect = 1'b0; stall = 1'b0;
    repeat (20) @(posedge clk);

    n_checks++;
    if (n_pops < 100) begin
      n_fail++;
      $display("FAIL throughput: got %0d accepted words, expected at least 100", n_pops);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
